count_arbiter: RTL and testbench
================================

# count_arbiter

Shares one WIDTH-bit up-counter between two requesters, each needing a timed interval of a requested length. A round-robin FSM grants the counter, counts 0..len, pulses a per-requester done, and releases. It sits beside the existing counter blocks and replaces per-client private counters where only one interval runs at a time.

## Interface
- WIDTH, 4, counter and length width
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- req  in  2  req[i]=1: requester i wants the counter; held until done[i] or to abort
- len0  in  WIDTH  terminal count for requester 0, sampled on the grant edge
- len1  in  WIDTH  terminal count for requester 1, sampled on the grant edge
- grant  out  2  one-hot or zero; owner of the counter
- done  out  2  one-cycle pulse to the owner at interval end
- busy  out  1  1 in any state other than IDLE
- q  out  WIDTH  current count value

## Operation
- States: IDLE, COUNT, DONE. All outputs registered.
- Reset (reset=0): state=IDLE, grant=0, done=0, busy=0, q=0, last-served pointer=1 (requester 0 wins the first tie), latched len=0.
- IDLE: if any req is set, grant at the next edge. One requester: grant it. Both: grant the one not equal to the pointer. The pointer updates to the granted index, len_i is latched, q=0, state goes to COUNT.
- COUNT: if q == latched len, go to DONE, q holds, done[owner]=1. Otherwise q=q+1, modulo 2^WIDTH, though wrap never occurs because len is at most 2^WIDTH-1.
- Abort: if req[owner]=0 when sampled in COUNT, go to IDLE with grant=0, q=0, no done. Abort takes priority over the terminal-count match on the same edge.
- DONE: lasts one cycle. Then go to IDLE with grant=0, q=0, done=0. req is ignored in DONE.
- Non-owner req never affects an in-progress interval. It is served from IDLE only.
- len inputs are ignored except on the grant edge.

## Timing
- req high before edge E0, counter idle → grant and busy high after E0, q=0.
- q=k during the k-th COUNT cycle (k = 0..len). There are len+1 COUNT cycles, then 1 DONE cycle. grant is high for len+2 cycles.
- done rises on the edge after the cycle in which q==len, and falls one edge later, coincident with grant falling.
- A requester still asserting req in the first IDLE cycle after DONE is re-eligible. With both requesting, the other requester wins. The IDLE gap between intervals is exactly 1 cycle.
- len=0: 1 COUNT cycle (q=0), then DONE.
- reset asserted mid-interval: all outputs clear asynchronously, with no done pulse. After release, operation resumes from IDLE with pointer=1.

## Structure
- Shared package count_arb_pkg: state encodings (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and the default WIDTH constant.
- Sub-module sync_counter (WIDTH; clk, reset, clr, en, q): a synchronous up-counter with clear priority over enable, using the same async active-low reset. It replaces the ripple structure so that q is glitch-free for the compare logic.
- count_arbiter holds the FSM, pointer, latched len, and the terminal compare.

## Test plan
- Single request: req=2'b01, len0=3 → grant=01 for 5 cycles. q sequence is 0,1,2,3,3. done[0] pulses in the 5th cycle. Then grant=00, busy=0.
- Tie after reset: req=2'b11, len0=1, len1=2 → requester 0 served first (3 cycles). After 1 IDLE cycle, requester 1 served (4 cycles, done[1] in its last cycle).
- Round-robin fairness: both requesters held high for 6 intervals with len=0 → grant alternates 01,10,01,10,01,10. Each done fires exactly 3 times.
- Abort: req0 drops when q=2 with len0=7 → next edge grant=00, q=0, busy=0, done never asserted. A pending req1 is then granted after the IDLE cycle.
- Boundary: len1=15, WIDTH=4 → q reaches 15 without wrap, done[1] fires, total grant of 17 cycles. Also: a len change during COUNT has no effect.
- Reset mid-interval: reset=0 while in COUNT at q=4 → grant, done, busy, and q go to 0 before the next clock edge. After release, req=2'b11 grants requester 0.

Source files
------------

// File: rtl/count_arb_pkg.sv
// -----------------------------------------------------------------------------
// count_arb_pkg
// Shared definitions for the count_arbiter slice:
//   - DEFAULT_WIDTH : default counter / interval-length width
//   - state_t       : arbiter FSM state encoding (IDLE=0, COUNT=1, DONE=2)
//   - pick_winner() : round-robin choice between the two requesters
// -----------------------------------------------------------------------------
package count_arb_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Returns the index of the requester to serve. With a single requester it
    // wins outright; on a tie the one that was not served last wins.
    // Only meaningful when at least one bit of req is set.
    function automatic logic pick_winner(input logic [1:0] req,
                                         input logic       last_served);
        logic winner;
        if (req == 2'b11) begin
            winner = ~last_served;
        end else begin
            winner = req[1];
        end
        return winner;
    endfunction

endpackage : count_arb_pkg

// File: rtl/count_arbiter_sync_counter.sv
// -----------------------------------------------------------------------------
// sync_counter
// Synchronous WIDTH-bit up-counter. Clear has priority over enable, so the
// owner of the counter can restart it in the same cycle it would otherwise
// count. All bits change on the same clock edge, keeping q glitch-free for
// downstream equality compares.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, forces q to 0
//   clr    in   synchronous clear (priority over en)
//   en     in   count enable, q <= q + 1 (modulo 2^WIDTH)
//   q      out  current count
// -----------------------------------------------------------------------------
module sync_counter
    import count_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule : sync_counter

// File: rtl/count_arbiter.sv
// -----------------------------------------------------------------------------
// count_arbiter
// Shares one WIDTH-bit up-counter between two requesters. A round-robin FSM
// grants the counter to one requester, counts 0..len, pulses that requester's
// done for one cycle, and returns to IDLE. Dropping req while counting aborts
// the interval without a done pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   req    in   [1:0] request per requester; held until done or to abort
//   len0   in   [WIDTH-1:0] terminal count for requester 0 (sampled at grant)
//   len1   in   [WIDTH-1:0] terminal count for requester 1 (sampled at grant)
//   grant  out  [1:0] one-hot owner of the counter, or zero
//   done   out  [1:0] one-cycle pulse to the owner at interval end
//   busy   out  high in any state other than IDLE
//   q      out  [WIDTH-1:0] current count value
//
// Timing summary: grant/busy rise on the edge that samples req in IDLE, with
// q=0. q walks 0..len over len+1 COUNT cycles, then one DONE cycle carries the
// done pulse, so grant is high for len+2 cycles. At least one IDLE cycle
// separates consecutive intervals.
// -----------------------------------------------------------------------------
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    state_t           state;
    logic             owner;        // index of the current grant holder
    logic             last_served;  // round-robin pointer
    logic [WIDTH-1:0] len_lat;      // terminal count captured at grant

    logic             next_owner;
    logic             abort;
    logic             term;
    logic             cnt_clr;
    logic             cnt_en;

    assign next_owner = pick_winner(req, last_served);

    // Owner withdrew its request; only acted on in COUNT.
    assign abort = ~req[owner];

    // q is a registered counter output, so this compare is glitch-free.
    assign term = (q == len_lat);

    // Counter control. The counter is held at zero everywhere except COUNT,
    // so every interval starts from 0 without an extra clear cycle. In COUNT
    // it advances until the terminal value, then holds for the DONE cycle.
    // An abort clears it on the same edge the FSM returns to IDLE.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        if (state == ST_COUNT && !abort) begin
            cnt_clr = 1'b0;
            cnt_en  = ~term;
        end
    end

    sync_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (q)
    );

    // Arbiter FSM with registered grant / done / busy.
    // last_served resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            len_lat     <= '0;
            grant       <= 2'b00;
            done        <= 2'b00;
            busy        <= 1'b0;
        end else begin
            done <= 2'b00;

            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state       <= ST_COUNT;
                        owner       <= next_owner;
                        last_served <= next_owner;
                        len_lat     <= next_owner ? len1 : len0;
                        grant       <= next_owner ? 2'b10 : 2'b01;
                        busy        <= 1'b1;
                    end
                end

                ST_COUNT: begin
                    // Abort wins over a terminal-count match on the same edge.
                    if (abort) begin
                        state <= ST_IDLE;
                        grant <= 2'b00;
                        busy  <= 1'b0;
                    end else if (term) begin
                        state <= ST_DONE;
                        done  <= grant;
                    end
                end

                ST_DONE: begin
                    // req is deliberately ignored here; the owner may already
                    // have dropped it after seeing the terminal count.
                    state <= ST_IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : count_arbiter

// File: tb/tb_count_arbiter.sv
// -----------------------------------------------------------------------------
// tb_count_arbiter
// Directed bench for count_arbiter. Stimulus pushes one expected interval
// record per grant it intends to cause; a monitor samples the DUT on every
// falling edge, pops a record when a grant starts, and compares grant owner,
// per-cycle q/done/busy and interval length against it.
// -----------------------------------------------------------------------------
module tb_count_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [1:0]   req;
    logic [W-1:0] len0;
    logic [W-1:0] len1;
    logic [1:0]   grant;
    logic [1:0]   done;
    logic         busy;
    logic [W-1:0] q;

    count_arbiter #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] gnt;
        int         len;
        bit         aborted;
        int         abort_cycles;
    } exp_t;

    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;
    int done_seen[2] = '{0, 0};
    int done_exp[2]  = '{0, 0};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic expect_iv(input logic [1:0] g, input int len,
                             input bit ab = 1'b0, input int ac = 0);
        exp_t e;
        e.gnt          = g;
        e.len          = len;
        e.aborted      = ab;
        e.abort_cycles = ac;
        sb.push_back(e);
        if (!ab) done_exp[g[1] ? 1 : 0]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        bit           in_iv;
        exp_t         cur;
        int           cyc;
        logic [W-1:0] eq;
        logic [1:0]   ed;
        in_iv = 1'b0;
        cyc   = 0;
        forever begin
            @(negedge clk);
            if (in_iv && grant !== cur.gnt) begin
                check("interval_cycles", cyc,
                      cur.aborted ? cur.abort_cycles : cur.len + 2);
                in_iv = 1'b0;
            end
            if (!in_iv && grant !== 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", {30'd0, grant}, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("grant_owner", {30'd0, grant}, {30'd0, cur.gnt});
                    in_iv = 1'b1;
                    cyc   = 0;
                end
            end
            if (in_iv) begin
                eq = (cyc <= cur.len) ? W'(cyc) : W'(cur.len);
                ed = (!cur.aborted && cyc == cur.len + 1) ? cur.gnt : 2'b00;
                check("cycle_busy_done_q", {25'd0, busy, done, q},
                      {25'd0, 1'b1, ed, eq});
                cyc++;
            end else begin
                check("idle_outputs", {25'd0, busy, done, q}, 32'd0);
            end
            if (done[0] === 1'b1) done_seen[0]++;
            if (done[1] === 1'b1) done_seen[1]++;
        end
    end

    // --------------------------------------------------------------- stimulus
    initial begin : stimulus
        int d0_before;
        int d1_before;

        reset = 1'b0;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        #1;
        check("reset_outputs", {23'd0, grant, done, busy, q}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Tie straight after reset: requester 0 first, then 1 after one IDLE.
        len0 = 4'd1;
        len1 = 4'd2;
        expect_iv(2'b01, 1);
        expect_iv(2'b10, 2);
        req = 2'b11;
        tick();
        repeat (2) tick();
        req = 2'b10;
        tick();
        tick();
        repeat (3) tick();
        req = 2'b00;
        repeat (3) tick();

        // Fairness: both held, len=0, six intervals alternating 01,10,...
        len0 = 4'd0;
        len1 = 4'd0;
        for (int i = 0; i < 6; i++) expect_iv((i % 2 == 0) ? 2'b01 : 2'b10, 0);
        d0_before = done_seen[0];
        d1_before = done_seen[1];
        req = 2'b11;
        repeat (17) tick();
        req = 2'b00;
        repeat (3) tick();
        check("fair_done0_count", done_seen[0] - d0_before, 3);
        check("fair_done1_count", done_seen[1] - d1_before, 3);

        // Abort: req0 drops while q=2 (len0=7); pending req1 served next.
        len0 = 4'd7;
        len1 = 4'd1;
        expect_iv(2'b01, 7, 1'b1, 3);
        expect_iv(2'b10, 1);
        req = 2'b11;
        tick();
        repeat (2) tick();
        req = 2'b10;
        tick();
        check("abort_cleared", {23'd0, grant, done, busy, q}, 32'd0);
        tick();
        repeat (2) tick();
        req = 2'b00;
        repeat (3) tick();

        // Single request, len0=3: q 0,1,2,3,3 with done in the fifth cycle.
        len0 = 4'd3;
        expect_iv(2'b01, 3);
        req = 2'b01;
        tick();
        repeat (4) tick();
        req = 2'b00;
        repeat (3) tick();
        check("idle_after_single", {30'd0, grant[1] | grant[0], busy}, 32'd0);

        // Boundary: len1=15 runs to 15 without wrap; len change mid-count ignored.
        len1 = 4'd15;
        expect_iv(2'b10, 15);
        req = 2'b10;
        tick();
        len1 = 4'd3;
        repeat (16) tick();
        req = 2'b00;
        repeat (3) tick();

        // Asynchronous reset while counting at q=4.
        len0 = 4'd9;
        expect_iv(2'b01, 9, 1'b1, 5);
        req = 2'b01;
        tick();
        repeat (4) tick();
        #5;
        reset = 1'b0;
        #1;
        check("async_reset_clear", {23'd0, grant, done, busy, q}, 32'd0);
        req = 2'b00;
        tick();
        reset = 1'b1;
        tick();

        // After reset the pointer is back to 1, so a tie goes to requester 0.
        len0 = 4'd2;
        len1 = 4'd1;
        expect_iv(2'b01, 2);
        expect_iv(2'b10, 1);
        req = 2'b11;
        tick();
        repeat (3) tick();
        req = 2'b10;
        tick();
        tick();
        repeat (2) tick();
        req = 2'b00;
        repeat (3) tick();

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("scoreboard_drained", sb.size(), 0);
        check("done0_total", done_seen[0], done_exp[0]);
        check("done1_total", done_seen[1], done_exp[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard bound so the run always ends even if the stimulus stalls.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_count_arbiter
